// File: rtl/alu_isa_pkg.sv
// ISA constants, instruction field positions and sequencer state encoding
// shared by the alu_seq_ctrl sequencer, its opcode decoder and its interface.
package alu_isa_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_MOVE  = 6'd5;
    localparam logic [5:0] OP_SGE   = 6'd6;
    localparam logic [5:0] OP_SLE   = 6'd7;
    localparam logic [5:0] OP_SGT   = 6'd8;
    localparam logic [5:0] OP_SLT   = 6'd9;
    localparam logic [5:0] OP_SEQ   = 6'd10;
    localparam logic [5:0] OP_SNE   = 6'd11;
    localparam logic [5:0] OP_AND   = 6'd12;
    localparam logic [5:0] OP_OR    = 6'd13;
    localparam logic [5:0] OP_XOR   = 6'd14;
    localparam logic [5:0] OP_NOT   = 6'd15;
    localparam logic [5:0] OP_MOVEI = 6'd16;
    localparam logic [5:0] OP_SLI   = 6'd17;
    localparam logic [5:0] OP_SRI   = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SUBI  = 6'd20;
    localparam logic [5:0] OP_JUMP  = 6'd21;
    localparam logic [5:0] OP_BRA   = 6'd22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef struct packed {
        logic legal;
        logic a_sel;
        logic b_sel;
        logic is_load;
        logic is_store;
        logic is_jump;
        logic is_bra;
        logic writes_rf;
    } dec_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer (master)
// and the memories (slave).
interface alu_seq_ctrl_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_data;
    logic            dmem_req;
    logic            dmem_we;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic            dmem_ack;
    logic [31:0]     dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_data, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_data, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: maps the 6-bit opcode onto the control
// attributes the sequencer needs to pick its state path and operand muxes.
module alu_op_decode
    import alu_isa_pkg::*;
(
    input  logic [5:0] op,
    output dec_t       dec
);
    always_comb begin
        dec           = '0;
        dec.legal     = (op <= OP_BRA);
        dec.a_sel     = (op == OP_MOVEI);
        dec.b_sel     = op inside {OP_STORE, OP_LOAD, OP_SLI, OP_SRI, OP_ADDI, OP_SUBI};
        dec.is_load   = (op == OP_LOAD);
        dec.is_store  = (op == OP_STORE);
        dec.is_jump   = (op == OP_JUMP);
        dec.is_bra    = (op == OP_BRA);
        // LOAD writes the register file too, but only after its MEM phase
        dec.writes_rf = dec.legal && !(op inside {OP_NOP, OP_STORE, OP_JUMP, OP_BRA});
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC.
// Optional retired-instruction counter enabled by `define ALU_SEQ_PERF_EN.
module alu_seq_ctrl
    import alu_isa_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    alu_seq_ctrl_if.master    mem,
    output logic [4:0]        rf_ra1,
    output logic [4:0]        rf_ra2,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    output logic [5:0]        alu_opc,
    output logic              alu_a_sel,
    output logic              alu_b_sel,
    output logic [31:0]       imm_ext,
    input  logic [31:0]       alu_result,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [31:0]       rf_wd,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              illegal_op
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]       instr_retired
`endif
);

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [31:0]     ir_reg;
    logic [31:0]     res_reg;
    logic [31:0]     wdata_reg;
    logic [31:0]     imm_reg;
    logic [31:0]     rf_wd_reg;
    logic [4:0]      ra1_reg;
    logic [4:0]      ra2_reg;
    logic [4:0]      rf_wa_reg;
    logic [5:0]      alu_opc_reg;
    logic            a_sel_reg;
    logic            b_sel_reg;
    logic            imem_req_reg;
    logic            dmem_req_reg;
    logic            dmem_we_reg;
    logic            rf_we_reg;
    logic            illegal_reg;

    logic [5:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    dec_t            dec;

    assign op  = ir_reg[OP_HI:OP_LO];
    assign rd  = ir_reg[RD_HI:RD_LO];
    assign rs1 = ir_reg[RS1_HI:RS1_LO];
    assign rs2 = ir_reg[RS2_HI:RS2_LO];

    alu_op_decode u_dec (
        .op  (op),
        .dec (dec)
    );

    logic            take_branch;
    logic            exec_done;
    logic            store_done;
    logic            last_cycle;
    logic [PC_W-1:0] pc_next;

    // rf_rd1 is only meaningful in EXEC, which is the only final state of JUMP/BRA
    assign take_branch = dec.is_jump | (dec.is_bra & (rf_rd1 != 32'd0));
    assign pc_next     = take_branch ? pc_reg + PC_W'(1) + imm_reg[PC_W-1:0]
                                     : pc_reg + PC_W'(1);
    assign exec_done   = (state_reg == ST_EXEC) &
                         ~(dec.is_load | dec.is_store | dec.writes_rf);
    assign store_done  = (state_reg == ST_MEM) & mem.dmem_ack & dec.is_store;
    assign last_cycle  = exec_done | store_done | (state_reg == ST_WB);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
            res_reg      <= '0;
            wdata_reg    <= '0;
            imm_reg      <= '0;
            rf_wd_reg    <= '0;
            ra1_reg      <= '0;
            ra2_reg      <= '0;
            rf_wa_reg    <= '0;
            alu_opc_reg  <= '0;
            a_sel_reg    <= 1'b0;
            b_sel_reg    <= 1'b0;
            imem_req_reg <= 1'b0;
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            rf_we_reg    <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            illegal_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        state_reg    <= ST_FETCH;
                        imem_req_reg <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem.imem_ack) begin
                        ir_reg       <= mem.imem_data;
                        imem_req_reg <= 1'b0;
                        state_reg    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ra1_reg     <= rs1;
                    ra2_reg     <= dec.is_store ? rd : rs2;
                    imm_reg     <= {{16{ir_reg[IMM_HI]}}, ir_reg[IMM_HI:IMM_LO]};
                    alu_opc_reg <= (dec.writes_rf | dec.is_store) ? op : OP_NOP;
                    a_sel_reg   <= dec.a_sel;
                    b_sel_reg   <= dec.b_sel;
                    illegal_reg <= ~dec.legal;
                    state_reg   <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_reg     <= alu_result;
                    wdata_reg   <= rf_rd2;
                    alu_opc_reg <= OP_NOP;
                    a_sel_reg   <= 1'b0;
                    b_sel_reg   <= 1'b0;
                    if (dec.is_load || dec.is_store) begin
                        state_reg    <= ST_MEM;
                        dmem_req_reg <= 1'b1;
                        dmem_we_reg  <= dec.is_store;
                    end else if (dec.writes_rf) begin
                        state_reg <= ST_WB;
                        rf_we_reg <= 1'b1;
                        rf_wa_reg <= rd;
                        rf_wd_reg <= alu_result;
                    end
                end
                ST_MEM: begin
                    if (mem.dmem_ack) begin
                        dmem_req_reg <= 1'b0;
                        dmem_we_reg  <= 1'b0;
                        if (dec.is_load) begin
                            state_reg <= ST_WB;
                            rf_we_reg <= 1'b1;
                            rf_wa_reg <= rd;
                            rf_wd_reg <= mem.dmem_rdata;
                        end
                    end
                end
                ST_WB: begin
                    rf_we_reg <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Common retirement: advance the PC and choose fetch or idle
            if (last_cycle) begin
                pc_reg       <= pc_next;
                state_reg    <= run ? ST_FETCH : ST_IDLE;
                imem_req_reg <= run;
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] retired_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_reg <= '0;
        end else if (last_cycle && dec.legal) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign instr_retired = retired_reg;
`endif

    assign mem.imem_req   = imem_req_reg;
    assign mem.imem_addr  = pc_reg;
    assign mem.dmem_req   = dmem_req_reg;
    assign mem.dmem_we    = dmem_we_reg;
    assign mem.dmem_addr  = res_reg;
    assign mem.dmem_wdata = wdata_reg;
    assign rf_ra1         = ra1_reg;
    assign rf_ra2         = ra2_reg;
    assign alu_opc        = alu_opc_reg;
    assign alu_a_sel      = a_sel_reg;
    assign alu_b_sel      = b_sel_reg;
    assign imm_ext        = imm_reg;
    assign rf_we          = rf_we_reg;
    assign rf_wa          = rf_wa_reg;
    assign rf_wd          = rf_wd_reg;
    assign pc             = pc_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign illegal_op     = illegal_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: small imem/dmem/register-file/ALU models
// around the DUT and one task per scenario with hand-computed expectations.
module tb_alu_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;
    logic [31:0] rf_rd1, rf_rd2, imm_ext, alu_result, rf_wd;
    logic [5:0]  alu_opc;
    logic        alu_a_sel, alu_b_sel, rf_we, busy, illegal_op;
    logic [15:0] pc;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] instr_retired;
`endif

    alu_seq_ctrl_if #(.PC_W(16)) bus ();

    alu_seq_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .mem        (bus),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .alu_opc    (alu_opc),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .pc         (pc),
        .busy       (busy),
        .illegal_op (illegal_op)
`ifdef ALU_SEQ_PERF_EN
        ,
        .instr_retired (instr_retired)
`endif
    );

    always #5 clock = ~clock;

    // Environment models
    logic [31:0] prog [64];
    logic [31:0] rf [32];
    logic        imem_ack_en = 1'b1;
    logic        late_ack = 1'b0;
    int          dmem_lat = 1;
    int          dmem_cnt = 0;
    logic [31:0] dmem_rdata_v = 32'hDEADBEEF;
    logic [31:0] opa, opb;

    assign bus.imem_ack   = (bus.imem_req & imem_ack_en) | late_ack;
    assign bus.imem_data  = prog[bus.imem_addr[5:0]];
    assign bus.dmem_ack   = (bus.dmem_req && (dmem_cnt == dmem_lat - 1)) || late_ack;
    assign bus.dmem_rdata = dmem_rdata_v;
    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    always @(posedge clock) begin
        if (!bus.dmem_req || bus.dmem_ack) dmem_cnt <= 0;
        else dmem_cnt <= dmem_cnt + 1;
    end

    always_comb begin
        opa = alu_a_sel ? imm_ext : rf_rd1;
        opb = alu_b_sel ? imm_ext : rf_rd2;
        case (alu_opc)
            6'd1, 6'd3, 6'd4, 6'd19: alu_result = opa + opb;
            6'd2, 6'd20:             alu_result = opa - opb;
            6'd5, 6'd16:             alu_result = opa;
            default:                 alu_result = 32'd0;
        endcase
    end

    // Free-running event monitors sampled at the active edge
    int n_illegal = 0, n_rf_we = 0, n_dmem = 0;
    always @(posedge clock) begin
        if (illegal_op)   n_illegal <= n_illegal + 1;
        if (rf_we)        n_rf_we   <= n_rf_we + 1;
        if (bus.dmem_req) n_dmem    <= n_dmem + 1;
    end

    int n_pass = 0, n_total = 0;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    // Issue one instruction from IDLE and count busy cycles (capped at 50)
    task automatic run_one(output int cyc);
        cyc = 0;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %h want 0", busy); else n_pass++;
        n_total++; if (pc !== 16'h0) $display("FAIL rst_pc got %h want 0", pc); else n_pass++;
        n_total++; if ({bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, illegal_op} !== 5'b0)
            $display("FAIL rst_req got %b want 00000", {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, illegal_op}); else n_pass++;
        n_total++; if ({alu_opc, imm_ext, rf_wd, bus.dmem_addr, bus.dmem_wdata} !== 134'd0)
            $display("FAIL rst_data got %h want 0", {alu_opc, imm_ext, rf_wd, bus.dmem_addr, bus.dmem_wdata}); else n_pass++;
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_total++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got %h want 0", busy); else n_pass++;
    endtask

    task automatic test_addi;
        rf[1] = 32'd10;
        prog[0] = enc(6'd19, 5'd3, 5'd1, 16'd5);
        run = 1'b1;
        @(negedge clock);
        n_total++; if ({bus.imem_req, busy, bus.imem_addr} !== {2'b11, 16'h0})
            $display("FAIL addi_fetch got %b/%h want 11/0000", {bus.imem_req, busy}, bus.imem_addr); else n_pass++;
        @(negedge clock);
        run = 1'b0;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL addi_decode_req got %h want 0", bus.imem_req); else n_pass++;
        @(negedge clock);
        n_total++; if (alu_opc !== 6'd19) $display("FAIL addi_opc got %0d want 19", alu_opc); else n_pass++;
        n_total++; if ({alu_a_sel, alu_b_sel} !== 2'b01) $display("FAIL addi_sel got %b want 01", {alu_a_sel, alu_b_sel}); else n_pass++;
        n_total++; if (imm_ext !== 32'd5) $display("FAIL addi_imm got %h want 5", imm_ext); else n_pass++;
        @(negedge clock);
        n_total++; if ({rf_we, rf_wa} !== {1'b1, 5'd3}) $display("FAIL addi_wb got we=%b wa=%0d want we=1 wa=3", rf_we, rf_wa); else n_pass++;
        n_total++; if (rf_wd !== 32'd15) $display("FAIL addi_wd got %h want f", rf_wd); else n_pass++;
        n_total++; if ({alu_opc, pc} !== {6'd0, 16'h0}) $display("FAIL addi_wb_opc_pc got %0d/%h want 0/0", alu_opc, pc); else n_pass++;
        @(negedge clock);
        n_total++; if ({busy, rf_we, pc} !== {2'b00, 16'h1}) $display("FAIL addi_end got busy=%b we=%b pc=%h want 0 0 1", busy, rf_we, pc); else n_pass++;
    endtask

    task automatic test_load;
        logic [3:0] req_hist;
        rf[4] = 32'h100;
        prog[1] = enc(6'd4, 5'd2, 5'd4, 16'd8);
        dmem_lat = 3;
        run = 1'b1;
        @(negedge clock);            // FETCH
        @(negedge clock);            // DECODE
        run = 1'b0;
        @(negedge clock);            // EXEC
        n_total++; if ({alu_opc, alu_b_sel} !== {6'd4, 1'b1}) $display("FAIL load_exec got %0d/%b want 4/1", alu_opc, alu_b_sel); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            req_hist[3-i] = bus.dmem_req;
            if (i == 0) begin
                n_total++; if ({bus.dmem_we, bus.dmem_addr} !== {1'b0, 32'h108})
                    $display("FAIL load_mem got we=%b addr=%h want 0 108", bus.dmem_we, bus.dmem_addr); else n_pass++;
            end
        end
        n_total++; if (req_hist !== 4'b1110) $display("FAIL load_req_hold got %b want 1110", req_hist); else n_pass++;
        n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd2, 32'hDEADBEEF})
            $display("FAIL load_wb got we=%b wa=%0d wd=%h want 1 2 deadbeef", rf_we, rf_wa, rf_wd); else n_pass++;
        @(negedge clock);
        n_total++; if ({busy, pc} !== {1'b0, 16'h2}) $display("FAIL load_end got busy=%b pc=%h want 0 2", busy, pc); else n_pass++;
        dmem_lat = 1;
    endtask

    task automatic test_branch;
        int cyc, we0, dm0;
        we0 = n_rf_we; dm0 = n_dmem;
        prog[2] = enc(6'd21, 5'd0, 5'd0, 16'd7);
        run_one(cyc);
        n_total++; if ({cyc[7:0], pc} !== {8'd3, 16'd10}) $display("FAIL jump_fwd got cyc=%0d pc=%h want 3 a", cyc, pc); else n_pass++;
        rf[5] = 32'd0;
        prog[10] = enc(6'd22, 5'd0, 5'd5, 16'hFFFD);
        run_one(cyc);
        n_total++; if (pc !== 16'd11) $display("FAIL bra_nt got %h want b", pc); else n_pass++;
        prog[11] = enc(6'd21, 5'd0, 5'd0, 16'hFFFE);
        run_one(cyc);
        n_total++; if (pc !== 16'd10) $display("FAIL jump_back got %h want a", pc); else n_pass++;
        rf[5] = 32'd7;
        run_one(cyc);
        n_total++; if ({cyc[7:0], pc} !== {8'd3, 16'd8}) $display("FAIL bra_taken got cyc=%0d pc=%h want 3 8", cyc, pc); else n_pass++;
        prog[8] = enc(6'd21, 5'd0, 5'd0, 16'd1);
        run_one(cyc);
        prog[10] = enc(6'd21, 5'd0, 5'd0, 16'h7FFF);
        run_one(cyc);
        n_total++; if (pc !== 16'h800A) $display("FAIL jump_wrap got %h want 800a", pc); else n_pass++;
        n_total++; if ({n_rf_we - we0, n_dmem - dm0} !== {32'd0, 32'd0})
            $display("FAIL branch_side got rf_we=%0d dmem=%0d want 0 0", n_rf_we - we0, n_dmem - dm0); else n_pass++;
    endtask

    task automatic test_illegal;
        int cyc, il0, we0, dm0;
        il0 = n_illegal; we0 = n_rf_we; dm0 = n_dmem;
        prog[10] = enc(6'd40, 5'd1, 5'd2, 16'd3);
        run_one(cyc);
        n_total++; if (cyc !== 3) $display("FAIL ill_cycles got %0d want 3", cyc); else n_pass++;
        n_total++; if (n_illegal - il0 !== 1) $display("FAIL ill_pulse got %0d want 1", n_illegal - il0); else n_pass++;
        n_total++; if ({n_rf_we - we0, n_dmem - dm0} !== {32'd0, 32'd0})
            $display("FAIL ill_side got rf_we=%0d dmem=%0d want 0 0", n_rf_we - we0, n_dmem - dm0); else n_pass++;
        n_total++; if (pc !== 16'h800B) $display("FAIL ill_pc got %h want 800b", pc); else n_pass++;
`ifdef ALU_SEQ_PERF_EN
        n_total++; if (instr_retired !== 32'd8) $display("FAIL ill_retired got %0d want 8", instr_retired); else n_pass++;
`endif
    endtask

    task automatic test_reset_store;
        rf[7] = 32'h20;
        rf[6] = 32'h55;
        prog[11] = enc(6'd3, 5'd6, 5'd7, 16'd4);
        dmem_lat = 100;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);            // MEM, ack pending
        n_total++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== {2'b11, 32'h24, 32'h55})
            $display("FAIL st_mem got req=%b we=%b addr=%h wd=%h want 1 1 24 55", bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if ({bus.dmem_req, bus.dmem_we, busy, pc} !== {3'b000, 16'h0})
            $display("FAIL st_rst got req=%b we=%b busy=%b pc=%h want 0 0 0 0", bus.dmem_req, bus.dmem_we, busy, pc); else n_pass++;
        n_total++; if ({bus.dmem_addr, bus.dmem_wdata} !== 64'd0)
            $display("FAIL st_rst_data got %h want 0", {bus.dmem_addr, bus.dmem_wdata}); else n_pass++;
        late_ack = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        n_total++; if ({busy, bus.imem_req, bus.dmem_req, pc} !== {3'b000, 16'h0})
            $display("FAIL st_idle got busy=%b ireq=%b dreq=%b pc=%h want 0 0 0 0", busy, bus.imem_req, bus.dmem_req, pc); else n_pass++;
`ifdef ALU_SEQ_PERF_EN
        n_total++; if (instr_retired !== 32'd0) $display("FAIL st_retired got %0d want 0", instr_retired); else n_pass++;
`endif
        late_ack = 1'b0;
        dmem_lat = 1;
    endtask

    task automatic test_run_drop;
        rf[1] = 32'd10;
        rf[4] = 32'h100;
        prog[0] = enc(6'd1, 5'd9, 5'd1, 16'h2000);
        run = 1'b1;
        @(negedge clock);            // FETCH
        @(negedge clock);            // DECODE
        @(negedge clock);            // EXEC
        run = 1'b0;
        n_total++; if (alu_opc !== 6'd1) $display("FAIL add_opc got %0d want 1", alu_opc); else n_pass++;
        @(negedge clock);            // WB
        n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h10A})
            $display("FAIL add_wb got we=%b wa=%0d wd=%h want 1 9 10a", rf_we, rf_wa, rf_wd); else n_pass++;
        @(negedge clock);
        @(negedge clock);
        n_total++; if ({busy, bus.imem_req, pc} !== {2'b00, 16'h1})
            $display("FAIL add_idle got busy=%b req=%b pc=%h want 0 0 1", busy, bus.imem_req, pc); else n_pass++;
        imem_ack_en = 1'b0;
        run = 1'b1;
        @(negedge clock);
        n_total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h1})
            $display("FAIL resume got req=%b addr=%h want 1 1", bus.imem_req, bus.imem_addr); else n_pass++;
        @(negedge clock);
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL fetch_hold got %b want 1", bus.imem_req); else n_pass++;
        run = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        @(negedge clock);
        @(negedge clock);
        test_reset;
        test_addi;
        test_load;
        test_branch;
        test_illegal;
        test_reset_store;
        test_run_drop;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
